// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared RV32I pipeline types.
//   rv32i_reg      : architectural register index (x0..x31)
//   hazard_state_t : memory-freeze sequencer state for pipeline_hazard_ctrl
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic {
    RUN,
    WAIT_MEM
  } hazard_state_t;

  localparam rv32i_reg REG_ZERO = 5'd0;

  // A source only collides when it is actually read and the producer is not x0.
  function automatic logic reg_hit(input rv32i_reg src, input logic used,
                                   input rv32i_reg dst);
    return used && (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the datapath and pipeline_hazard_ctrl.
//   Datapath -> control : ID sources, EX/MEM destinations and load flags,
//                         EX redirect, imem/dmem request and response.
//   Control -> datapath : stage load enables, IF/ID and ID/EX flushes, frozen.
// master = datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if;
  import rv32i_types::*;

  rv32i_reg IFID_rs1;
  rv32i_reg IFID_rs2;
  logic     IFID_uses_rs1;
  logic     IFID_uses_rs2;
  rv32i_reg IDEX_rd;
  logic     IDEX_mem_read;
  rv32i_reg EXMEM_rd;
  logic     EXMEM_mem_read;
  logic     ex_redirect;
  logic     imem_read;
  logic     imem_resp;
  logic     dmem_req;
  logic     dmem_resp;

  logic     load_pc;
  logic     load_ifid;
  logic     load_idex;
  logic     load_exmem;
  logic     load_memwb;
  logic     flush_ifid;
  logic     flush_idex;
  logic     frozen;

  modport master (
    output IFID_rs1, IFID_rs2, IFID_uses_rs1, IFID_uses_rs2,
           IDEX_rd, IDEX_mem_read, EXMEM_rd, EXMEM_mem_read,
           ex_redirect, imem_read, imem_resp, dmem_req, dmem_resp,
    input  load_pc, load_ifid, load_idex, load_exmem, load_memwb,
           flush_ifid, flush_idex, frozen
  );

  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_uses_rs1, IFID_uses_rs2,
           IDEX_rd, IDEX_mem_read, EXMEM_rd, EXMEM_mem_read,
           ex_redirect, imem_read, imem_resp, dmem_req, dmem_resp,
    output load_pc, load_ifid, load_idex, load_exmem, load_memwb,
           flush_ifid, flush_idex, frozen
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, synchronous active-high clear
//   inc      : count this cycle (ignored once all-ones)
//   count    : current value
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
//   clk, rst      : clock, synchronous active-high reset
//   hz_if (slave) : hazard inputs from the datapath, stage enables/flushes out
//   stall_cycles  : saturating count of frozen or load-use bubble cycles
//   flush_count   : saturating count of redirect flushes
// Memory waits freeze every stage; a load-use hit inserts an ID/EX bubble;
// an EX redirect squashes IF/ID and ID/EX and overrides the load-use bubble.
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz_if,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  hazard_state_t state_q, state_d;
  logic imem_done_q, imem_done_d;
  logic dmem_done_q, dmem_done_d;

  logic mem_wait;
  logic hz;
  logic bubble;
  logic flush_inc;
  logic stall_inc;

  // A response seen earlier in the stall (done flag) or in this very cycle
  // satisfies its side, so release happens on the last outstanding response.
  assign mem_wait = (hz_if.imem_read & ~(hz_if.imem_resp | imem_done_q))
                  | (hz_if.dmem_req  & ~(hz_if.dmem_resp | dmem_done_q));

  // MEM forwards ALU results only, so a load in either EX or MEM blocks.
  assign hz = (hz_if.IDEX_mem_read &
                (reg_hit(hz_if.IFID_rs1, hz_if.IFID_uses_rs1, hz_if.IDEX_rd) |
                 reg_hit(hz_if.IFID_rs2, hz_if.IFID_uses_rs2, hz_if.IDEX_rd)))
            | (hz_if.EXMEM_mem_read &
                (reg_hit(hz_if.IFID_rs1, hz_if.IFID_uses_rs1, hz_if.EXMEM_rd) |
                 reg_hit(hz_if.IFID_rs2, hz_if.IFID_uses_rs2, hz_if.EXMEM_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_done_d = 1'b0;
    dmem_done_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d     = WAIT_MEM;
          imem_done_d = hz_if.imem_read & hz_if.imem_resp;
          dmem_done_d = hz_if.dmem_req & hz_if.dmem_resp;
        end
      end
      WAIT_MEM: begin
        if (mem_wait) begin
          imem_done_d = imem_done_q | (hz_if.imem_read & hz_if.imem_resp);
          dmem_done_d = dmem_done_q | (hz_if.dmem_req & hz_if.dmem_resp);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    hz_if.load_pc    = 1'b1;
    hz_if.load_ifid  = 1'b1;
    hz_if.load_idex  = 1'b1;
    hz_if.load_exmem = 1'b1;
    hz_if.load_memwb = 1'b1;
    hz_if.flush_ifid = 1'b0;
    hz_if.flush_idex = 1'b0;
    hz_if.frozen     = 1'b0;
    bubble           = 1'b0;
    flush_inc        = 1'b0;
    if (rst) begin
      hz_if.load_pc    = 1'b0;
      hz_if.load_ifid  = 1'b0;
      hz_if.load_idex  = 1'b0;
      hz_if.load_exmem = 1'b0;
      hz_if.load_memwb = 1'b0;
      hz_if.flush_ifid = 1'b1;
      hz_if.flush_idex = 1'b1;
    end else if (mem_wait) begin
      hz_if.load_pc    = 1'b0;
      hz_if.load_ifid  = 1'b0;
      hz_if.load_idex  = 1'b0;
      hz_if.load_exmem = 1'b0;
      hz_if.load_memwb = 1'b0;
      hz_if.frozen     = 1'b1;
    end else if (hz_if.ex_redirect) begin
      hz_if.flush_ifid = 1'b1;
      hz_if.flush_idex = 1'b1;
      flush_inc        = 1'b1;
    end else if (hz) begin
      hz_if.load_pc    = 1'b0;
      hz_if.load_ifid  = 1'b0;
      hz_if.flush_idex = 1'b1;
      bubble           = 1'b1;
    end
  end

  assign stall_inc = hz_if.frozen | bubble;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW = 4;

  // {load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex, frozen}
  localparam logic [7:0] RUNALL = 8'b11111_00_0;
  localparam logic [7:0] BUBBLE = 8'b00111_01_0;
  localparam logic [7:0] FROZEN = 8'b00000_00_1;
  localparam logic [7:0] RESETV = 8'b00000_11_0;
  localparam logic [7:0] REDIR  = 8'b11111_11_0;

  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_count;
  int passed = 0;
  int total  = 0;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .hz_if        (hif),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {hif.load_pc, hif.load_ifid, hif.load_idex, hif.load_exmem,
            hif.load_memwb, hif.flush_ifid, hif.flush_idex, hif.frozen};
  endfunction

  task automatic idle();
    hif.IFID_rs1       = '0;
    hif.IFID_rs2       = '0;
    hif.IFID_uses_rs1  = 1'b0;
    hif.IFID_uses_rs2  = 1'b0;
    hif.IDEX_rd        = '0;
    hif.IDEX_mem_read  = 1'b0;
    hif.EXMEM_rd       = '0;
    hif.EXMEM_mem_read = 1'b0;
    hif.ex_redirect    = 1'b0;
    hif.imem_read      = 1'b0;
    hif.imem_resp      = 1'b0;
    hif.dmem_req       = 1'b0;
    hif.dmem_resp      = 1'b0;
  endtask

  task automatic check_ctl(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = ctl();
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s ctl: got %b expected %b", tag, obs, exp);
  endtask

  task automatic check_cnt(input string tag, input logic [CW-1:0] obs,
                           input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] exp_ctl,
                     input int exp_stall, input int exp_flush);
    @(negedge clk);
    check_ctl(tag, exp_ctl);
    check_cnt({tag, " stall_cycles"}, stall_cycles, CW'(exp_stall));
    check_cnt({tag, " flush_count"}, flush_count, CW'(exp_flush));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle();
    @(negedge clk);
    check_ctl(tag, RESETV);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset("reset");

    // lw x5 in EX, add x6,x5,x1 in ID: two bubbles
    hif.IFID_rs1 = 5'd5; hif.IFID_uses_rs1 = 1'b1;
    hif.IFID_rs2 = 5'd1; hif.IFID_uses_rs2 = 1'b1;
    hif.IDEX_rd = 5'd5; hif.IDEX_mem_read = 1'b1;
    cyc("lu_bubble1", BUBBLE, 0, 0);
    hif.IDEX_rd = 5'd0; hif.IDEX_mem_read = 1'b0;
    hif.EXMEM_rd = 5'd5; hif.EXMEM_mem_read = 1'b1;
    cyc("lu_bubble2", BUBBLE, 1, 0);
    hif.EXMEM_rd = 5'd0; hif.EXMEM_mem_read = 1'b0;
    cyc("lu_release", RUNALL, 2, 0);

    // load to x0 never blocks
    do_reset("reset_t2");
    hif.IFID_rs1 = 5'd0; hif.IFID_uses_rs1 = 1'b1;
    hif.IDEX_rd = 5'd0; hif.IDEX_mem_read = 1'b1;
    cyc("x0_ex", RUNALL, 0, 0);
    hif.IDEX_mem_read = 1'b0;
    hif.EXMEM_rd = 5'd0; hif.EXMEM_mem_read = 1'b1;
    cyc("x0_mem", RUNALL, 0, 0);
    idle();
    cyc("x0_after", RUNALL, 0, 0);

    // fetch miss for 4 cycles
    do_reset("reset_t3");
    hif.imem_read = 1'b1;
    cyc("imiss_c1", FROZEN, 0, 0);
    cyc("imiss_c2", FROZEN, 1, 0);
    cyc("imiss_c3", FROZEN, 2, 0);
    cyc("imiss_c4", FROZEN, 3, 0);
    hif.imem_resp = 1'b1;
    cyc("imiss_release", RUNALL, 4, 0);
    idle();
    cyc("imiss_run", RUNALL, 4, 0);

    // imem resp at cycle 1, dmem resp at cycle 5
    do_reset("reset_t4");
    hif.imem_read = 1'b1; hif.dmem_req = 1'b1;
    cyc("both_c0", FROZEN, 0, 0);
    hif.imem_resp = 1'b1;
    cyc("both_c1_imem_resp", FROZEN, 1, 0);
    hif.imem_resp = 1'b0;
    cyc("both_c2", FROZEN, 2, 0);
    cyc("both_c3", FROZEN, 3, 0);
    cyc("both_c4", FROZEN, 4, 0);
    hif.dmem_resp = 1'b1;
    cyc("both_c5_release", RUNALL, 5, 0);
    hif.dmem_req = 1'b0; hif.dmem_resp = 1'b0;
    cyc("done_cleared", FROZEN, 5, 0);
    hif.imem_resp = 1'b1;
    cyc("done_cleared_rel", RUNALL, 6, 0);
    idle();
    cyc("both_after", RUNALL, 6, 0);

    // redirect beats load-use; redirect during freeze waits for release
    do_reset("reset_t5");
    hif.IFID_rs1 = 5'd7; hif.IFID_uses_rs1 = 1'b1;
    hif.IDEX_rd = 5'd7; hif.IDEX_mem_read = 1'b1;
    hif.ex_redirect = 1'b1;
    cyc("redir_hz", REDIR, 0, 0);
    hif.imem_read = 1'b1;
    cyc("redir_frozen", FROZEN, 0, 1);
    hif.imem_resp = 1'b1;
    cyc("redir_release", REDIR, 1, 1);
    idle();
    cyc("redir_after", RUNALL, 1, 2);

    // reset in the middle of WAIT_MEM drops the done flags
    do_reset("reset_t6");
    hif.imem_read = 1'b1; hif.dmem_req = 1'b1;
    cyc("abort_c0", FROZEN, 0, 0);
    hif.imem_resp = 1'b1;
    cyc("abort_c1", FROZEN, 1, 0);
    rst = 1'b1;
    hif.imem_resp = 1'b0;
    cyc("abort_rst", RESETV, 2, 0);
    rst = 1'b0;
    hif.dmem_req = 1'b0;
    cyc("abort_no_flag", FROZEN, 0, 0);
    idle();
    cyc("abort_run", RUNALL, 1, 0);

    // saturation of the 4-bit stall counter
    do_reset("reset_sat");
    hif.imem_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc("sat", FROZEN, (i > 15) ? 15 : i, 0);
    end
    idle();
    cyc("sat_final", RUNALL, 15, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
